// File: rtl/median_driver_if.sv
// median_driver_if: window input, MEDIAN burst bus and result output of the median driver.
interface median_driver_if #(
    parameter int WIDTH = 8,
    parameter int NPIX  = 9
);
    logic [NPIX*WIDTH-1:0] WIN;
    logic                  WIN_VALID;
    logic                  WIN_READY;
    logic [WIDTH-1:0]      MED_DI;
    logic                  MED_DSI;
    logic [WIDTH-1:0]      MED_DO;
    logic                  MED_DSO;
    logic [WIDTH-1:0]      RES;
    logic                  RES_VALID;
    logic                  RES_READY;
    logic                  ERR;

    modport master (
        input  WIN, WIN_VALID, MED_DO, MED_DSO, RES_READY,
        output WIN_READY, MED_DI, MED_DSI, RES, RES_VALID, ERR
    );

    modport slave (
        output WIN, WIN_VALID, MED_DO, MED_DSO, RES_READY,
        input  WIN_READY, MED_DI, MED_DSI, RES, RES_VALID, ERR
    );
endinterface

// File: rtl/median_driver.sv
// median_driver: serialises a 3x3 window into a MEDIAN DSI burst and returns its median
// through a valid/ready handshake, aborting with ERR if MEDIAN never answers.
module median_driver #(
    parameter int WIDTH   = 8,
    parameter int NPIX    = 9,
    parameter int TIMEOUT = 64,
    parameter int TW      = 7
) (
    input logic             CLK,
    input logic             RST,
    median_driver_if.master bus
);
    localparam int CW = $clog2(NPIX + 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT, HOLD} state_t;

    state_t                state;
    logic [NPIX*WIDTH-1:0] buffer;
    logic [CW-1:0]         cnt;
    logic [TW-1:0]         tcnt;

    assign bus.WIN_READY = state == IDLE;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= IDLE;
            buffer        <= '0;
            cnt           <= '0;
            tcnt          <= '0;
            bus.MED_DI    <= '0;
            bus.MED_DSI   <= 1'b0;
            bus.RES       <= '0;
            bus.RES_VALID <= 1'b0;
            bus.ERR       <= 1'b0;
        end else begin
            bus.ERR <= 1'b0;
            case (state)
                IDLE: if (bus.WIN_VALID) begin
                    buffer      <= bus.WIN;
                    bus.MED_DI  <= bus.WIN[WIDTH-1:0];
                    bus.MED_DSI <= 1'b1;
                    cnt         <= CW'(1);
                    state       <= SEND;
                end
                SEND: if (cnt == CW'(NPIX)) begin
                    bus.MED_DI  <= '0;
                    bus.MED_DSI <= 1'b0;
                    tcnt        <= '0;
                    state       <= WAIT;
                end else begin
                    bus.MED_DI <= buffer[cnt*WIDTH +: WIDTH];
                    cnt        <= cnt + CW'(1);
                end
                WAIT: begin
                    tcnt <= tcnt + TW'(1);
                    // a strobe arriving on the last allowed cycle still counts as an answer
                    if (bus.MED_DSO) begin
                        bus.RES       <= bus.MED_DO;
                        bus.RES_VALID <= 1'b1;
                        state         <= HOLD;
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        bus.ERR <= 1'b1;
                        state   <= IDLE;
                    end
                end
                HOLD: if (bus.RES_READY) begin
                    bus.RES_VALID <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_median_driver.sv
// tb_median_driver: random and directed checks of median_driver against a sorting
// reference and a behavioural MEDIAN responder.
module tb_median_driver;
    localparam int W = 8;
    localparam int N = 9;

    logic clk, rst;
    int   cyc = 0;
    int   n_chk = 0, n_fail = 0;

    median_driver_if #(.WIDTH(W), .NPIX(N)) bus ();

    median_driver #(.WIDTH(W), .NPIX(N), .TIMEOUT(64), .TW(7)) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    logic         auto_resp = 1'b1, sb_en = 1'b0;
    logic         m_dso = 1'b0, o_dso = 1'b0;
    logic [W-1:0] m_do = '0, o_do = '0;
    int           last_w = 0, dso_cyc = 0;
    logic [N*W-1:0] last_px = '0;

    assign bus.MED_DSO = auto_resp ? m_dso : o_dso;
    assign bus.MED_DO  = auto_resp ? m_do : o_do;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [N*W-1:0] got, input logic [N*W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] median_of(input logic [N*W-1:0] w);
        logic [W-1:0] q[$];
        for (int i = 0; i < N; i++) q.push_back(w[i*W +: W]);
        q.sort();
        return q[N/2];
    endfunction

    function automatic logic [N*W-1:0] rnd_win();
        logic [N*W-1:0] w;
        for (int i = 0; i < N; i++) w[i*W +: W] = W'($urandom);
        return w;
    endfunction

    // Behavioural MEDIAN: collects each DSI burst and answers a few cycles after it ends.
    initial begin
        int           cd, wid, gap;
        logic         pd, prev;
        logic [W-1:0] mv;
        logic [N*W-1:0] sh;
        cd = 0; wid = 0; gap = 100; pd = 0; prev = 0; mv = '0; sh = '0;
        forever begin
            @(negedge clk);
            m_dso = 1'b0;
            if (bus.MED_DSI) begin
                if (!prev && sb_en) chk("dsi_gap", gap >= 2, 1);
                sh = {bus.MED_DI, sh[N*W-1:W]};
                wid++;
                gap = 0;
            end else begin
                gap++;
                if (pd) begin
                    cd--;
                    if (cd == 0) begin
                        m_dso = 1'b1; m_do = mv; dso_cyc = cyc; pd = 0;
                    end
                end
                if (prev) begin
                    last_w = wid; last_px = sh;
                    if (sb_en) chk("dsi_width", wid, N);
                    if (wid == N) begin
                        mv = median_of(sh); pd = 1; cd = $urandom_range(1, 3);
                    end
                    wid = 0;
                end
            end
            prev = bus.MED_DSI;
        end
    end

    task automatic do_reset();
        rst = 1'b1; bus.WIN_VALID = 1'b0; bus.RES_READY = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_win(input logic [N*W-1:0] w);
        @(negedge clk);
        bus.WIN = w; bus.WIN_VALID = 1'b1;
        @(negedge clk);
        bus.WIN_VALID = 1'b0;
    endtask

    task automatic wait_res(output logic ok, output int busy);
        ok = 0; busy = 0;
        for (int i = 0; i < 200; i++) begin
            if (bus.RES_VALID) begin ok = 1; break; end
            if (bus.WIN_READY) busy++;
            @(negedge clk);
        end
    endtask

    initial begin
        logic           ok;
        int             busy, bad, rv, k, got;
        logic [N*W-1:0] w1;
        logic [W-1:0]   exp_q[$];
        logic           acc;
        rst = 1'b1; bus.WIN = '0; bus.WIN_VALID = 1'b0; bus.RES_READY = 1'b0;
        do_reset();
        @(negedge clk);
        chk("rst_win_ready", bus.WIN_READY, 1);
        chk("rst_dsi", bus.MED_DSI, 0);
        chk("rst_di", bus.MED_DI, 0);
        chk("rst_res", bus.RES, 0);
        chk("rst_res_valid", bus.RES_VALID, 0);
        chk("rst_err", bus.ERR, 0);

        // directed window, result held with RES_READY low
        w1 = {8'd64, 8'd128, 8'd0, 8'd255, 8'd3, 8'd99, 8'd17, 8'd200, 8'd5};
        send_win(w1);
        chk("first_dsi", bus.MED_DSI, 1);
        chk("first_di", bus.MED_DI, 5);
        chk("busy_win_ready", bus.WIN_READY, 0);
        wait_res(ok, busy);
        chk("res_seen", ok, 1);
        chk("burst_width", last_w, N);
        chk("burst_pixels", last_px, w1);
        chk("res_value", bus.RES, 64);
        chk("dso_to_valid", cyc - dso_cyc, 1);
        chk("win_ready_during_burst", busy, 0);
        bad = 0;
        bus.WIN = rnd_win(); bus.WIN_VALID = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (bus.RES !== 8'd64 || bus.RES_VALID !== 1'b1 || bus.WIN_READY !== 1'b0) bad++;
        end
        chk("hold_stable", bad, 0);
        bus.WIN_VALID = 1'b0; bus.RES_READY = 1'b1;
        @(negedge clk);
        chk("release_valid", bus.RES_VALID, 0);
        chk("release_idle", bus.WIN_READY, 1);

        // silent MEDIAN: timeout
        auto_resp = 1'b0;
        send_win(rnd_win());
        for (int i = 0; i < 20 && bus.MED_DSI; i++) @(negedge clk);
        k = 0; rv = 0;
        for (int i = 0; i < 200 && !bus.ERR; i++) begin
            @(negedge clk);
            k++;
            if (bus.RES_VALID) rv++;
        end
        chk("err_delay", k, 64);
        chk("timeout_no_result", rv, 0);
        @(negedge clk);
        chk("err_one_cycle", bus.ERR, 0);
        chk("timeout_idle", bus.WIN_READY, 1);

        // reset in the 4th burst cycle
        auto_resp = 1'b1;
        send_win(rnd_win());
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_dsi", bus.MED_DSI, 0);
        chk("midrst_idle", bus.WIN_READY, 1);
        rv = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.RES_VALID) rv++;
        end
        chk("midrst_no_result", rv, 0);
        send_win({N{8'd7}});
        wait_res(ok, busy);
        chk("after_rst_seen", ok, 1);
        chk("after_rst_res", bus.RES, 7);

        // back-to-back random windows
        sb_en = 1'b1; got = 0; acc = 0;
        bus.WIN = rnd_win(); bus.WIN_VALID = 1'b1;
        for (int g = 0; g < 40000 && got < 1000; g++) begin
            @(negedge clk);
            if (acc) begin bus.WIN = rnd_win(); acc = 0; end
            if (bus.RES_VALID) begin
                if (exp_q.size() == 0) chk("b2b_unexpected", 1, 0);
                else chk("b2b_res", bus.RES, exp_q.pop_front());
                got++;
            end
            if (bus.WIN_READY) begin exp_q.push_back(median_of(bus.WIN)); acc = 1; end
        end
        chk("b2b_count", got, 1000);
        sb_en = 1'b0;
        do_reset();

        // answer on the very last WAIT cycle beats the timeout
        auto_resp = 1'b0; bus.RES_READY = 1'b0;
        send_win(rnd_win());
        for (int i = 0; i < 20 && bus.MED_DSI; i++) @(negedge clk);
        repeat (63) @(negedge clk);
        o_do = 8'd42; o_dso = 1'b1;
        @(negedge clk);
        o_dso = 1'b0;
        chk("race_res", bus.RES, 42);
        chk("race_valid", bus.RES_VALID, 1);
        chk("race_err", bus.ERR, 0);
        @(negedge clk);
        chk("race_err_after", bus.ERR, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/median_driver.md
Name: median_driver

Overview:
- Initiator side of the MEDIAN burst protocol.
- Accepts one 3x3 window (9 pixels, parallel) per valid/ready handshake and serialises it onto the MEDIAN input bus as a 9-cycle DSI burst.
- Waits for MEDIAN's DSO strobe, captures the median value and presents it downstream with a valid/ready handshake.
- Sits between the window extractor and the MEDIAN core in the filter pipeline; a timeout flags a MEDIAN that never answers.

Parameters:
- WIDTH, 8, pixel width in bits.
- NPIX, 9, pixels per burst (window size).
- TIMEOUT, 64, maximum cycles in WAIT before abort; must be >= 1.
- TW, 7, timeout counter width; must satisfy 2**TW > TIMEOUT.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  synchronous reset, active-high.
- WIN  in  NPIX*WIDTH  window pixels; pixel k = WIN[k*WIDTH +: WIDTH].
- WIN_VALID  in  1  WIN holds a window.
- WIN_READY  out  1  driver can accept a window.
- MED_DI  out  WIDTH  pixel to MEDIAN (its DI).
- MED_DSI  out  1  burst strobe to MEDIAN (its DSI).
- MED_DO  in  WIDTH  median from MEDIAN (its DO).
- MED_DSO  in  1  result strobe from MEDIAN (its DSO).
- RES  out  WIDTH  captured median.
- RES_VALID  out  1  RES valid.
- RES_READY  in  1  downstream accepts RES.
- ERR  out  1  one-cycle pulse on timeout abort.

Behaviour:
- All outputs are registered except WIN_READY, which is (state==IDLE).
- Reset values: state=IDLE, MED_DI=0, MED_DSI=0, RES=0, RES_VALID=0, ERR=0, pixel counter=0, timeout counter=0.
- RST has priority over every other input; RST asserted mid-burst drops MED_DSI at the next edge and discards the window and any pending result.

States:
- IDLE:
  - WIN_READY=1.
  - On WIN_VALID=1, latch WIN into an internal buffer, drive MED_DI=pixel 0 and MED_DSI=1, set counter=1, go to SEND.
- SEND:
  - Each cycle drive MED_DI=pixel[counter] and increment counter.
  - MED_DSI stays 1 for exactly NPIX consecutive cycles (pixels 0..NPIX-1 in order).
  - After pixel NPIX-1 has been presented for one cycle, MED_DSI=0, MED_DI=0 and the state goes to WAIT with the timeout counter cleared.
  - MED_DSO is ignored in SEND.
  - WIN changes during SEND have no effect.
- WAIT:
  - The timeout counter increments each cycle.
  - If MED_DSO=1, RES<=MED_DO, RES_VALID<=1 and the state goes to HOLD.
  - Else, if the counter reaches TIMEOUT-1, ERR pulses for one cycle and the state goes to IDLE with no result.
  - If MED_DSO arrives in the same cycle the timeout is reached, MED_DSO wins and no ERR is raised.
- HOLD:
  - RES and RES_VALID are held stable until RES_READY=1.
  - On that edge RES_VALID<=0 and the state goes to IDLE.
  - MED_DSO is ignored in HOLD.

Timing:
- Latency from window acceptance to the first MED_DSI cycle is 1 clock.
- Latency from MED_DSO to RES_VALID is 1 clock.
- There are always >= 2 cycles with MED_DSI=0 between bursts (WAIT + HOLD + IDLE), which satisfies MEDIAN's inter-burst gap.

Throughput:
- One window per NPIX + (MEDIAN latency) + 3 cycles, assuming RES_READY is held high.

Test Plan:
- Reset, then WIN = pixels {5,200,17,99,3,255,0,128,64} with WIN_VALID=1 and MEDIAN attached:
  - MED_DSI high for exactly 9 cycles, MED_DI sequence 5,200,17,...,64.
  - RES=64 with RES_VALID one cycle after MED_DSO; WIN_READY=0 throughout.
- Hold RES_READY=0 for 20 cycles after RES_VALID:
  - RES stays 64 and RES_VALID stays 1; no new window is accepted (WIN_READY=0).
  - RES_READY=1 returns the block to IDLE on the next edge.
- Tie MED_DSO low after a burst with TIMEOUT=64:
  - ERR=1 for one cycle exactly 64 cycles after MED_DSI falls.
  - RES_VALID never asserts; WIN_READY=1 on the following cycle.
- Assert RST on the 4th cycle of a burst:
  - MED_DSI=0 and WIN_READY=1 after that edge; no RES_VALID is produced.
  - A following window {9 x 7} yields RES=7.
- Back-to-back with WIN_VALID and RES_READY held high over 1000 random windows:
  - Every RES equals the sorted element 4 of its window.
  - MED_DSI pulse width is always 9, and the gap between pulses is always >= 2 cycles.
- Drive MED_DSO=1 in the same cycle the timeout counter reaches TIMEOUT-1 with MED_DO=42:
  - RES=42 and RES_VALID=1; ERR stays 0.
